// File: rtl/flit_mon_pkg.sv
// Shared types and default widths for the flit activity monitor.
package flit_mon_pkg;

    localparam int DEF_DATA_W   = 54;
    localparam int DEF_CNT_W    = 16;
    localparam int DEF_LEN_W    = 8;
    localparam int DEF_MAX_LEN  = 255;
    localparam int DEF_IDLE_GAP = 4;

    typedef enum logic {
        IDLE,
        OPEN
    } state_t;

    // Statistics record in the default configuration.
    typedef struct packed {
        logic [DEF_LEN_W-1:0] len;
        logic [DEF_CNT_W-1:0] toggles;
        logic [DEF_LEN_W-1:0] seq_err;
    } stat_t;

endpackage

// File: rtl/popcount_tree.sv
// Combinational popcount built as a balanced binary adder tree over a padded heap.
module popcount_tree #(
    parameter int W     = 54,
    parameter int OUT_W = $clog2(W + 1)
) (
    input  logic [W-1:0]     in_bits,
    output logic [OUT_W-1:0] count
);

    localparam int LVL = $clog2(W);
    localparam int P   = 1 << LVL;

    // Heap layout: leaves at P..2P-1, node i sums children 2i and 2i+1.
    logic [OUT_W-1:0] node [2*P];

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        node = '{default: '0};
        for (int i = 0; i < W; i++) begin
            node[P+i] = OUT_W'(in_bits[i]);
        end
        for (int i = P - 1; i >= 1; i--) begin
            node[i] = node[2*i] + node[2*i+1];
        end
        count = node[1];
    end

endmodule

// File: rtl/flit_activity_monitor.sv
// Per-packet switching-activity monitor for the flit injection stream.
// Optional thermometer-walk sequence checker enabled by THERMO_CHECK_EN.
module flit_activity_monitor
    import flit_mon_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int LEN_W    = DEF_LEN_W,
    parameter int MAX_LEN  = DEF_MAX_LEN,
    parameter int IDLE_GAP = DEF_IDLE_GAP
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flit_valid,
    input  logic [DATA_W-1:0] flit_data,
    output logic              stat_valid,
    input  logic              stat_ready,
    output logic [LEN_W-1:0]  stat_len,
    output logic [CNT_W-1:0]  stat_toggles,
    output logic [LEN_W-1:0]  stat_seq_err,
    output logic [7:0]        drop_cnt,
    output logic              busy
);

    localparam int TOG_W = $clog2(DATA_W + 1);
    localparam int GAP_W = $clog2(IDLE_GAP + 1);

    typedef struct packed {
        logic [LEN_W-1:0] len;
        logic [CNT_W-1:0] toggles;
        logic [LEN_W-1:0] seq_err;
    } rec_t;

    state_t            state;
    logic [DATA_W-1:0] prev_flit;
    logic [LEN_W-1:0]  len;
    logic [CNT_W-1:0]  acc;
    logic [LEN_W-1:0]  seq_err;
    logic [GAP_W-1:0]  gap_cnt;
    logic [TOG_W-1:0]  toggle;
    logic              flit_err;
    rec_t              rec;

    popcount_tree #(
        .W    (DATA_W),
        .OUT_W(TOG_W)
    ) u_popcount (
        .in_bits(flit_data ^ prev_flit),
        .count  (toggle)
    );

`ifdef THERMO_CHECK_EN
    logic              primed;
    logic [DATA_W-1:0] expect_flit;

    // Walk: 0 -> fill 1s from MSB -> all ones -> drain from MSB -> 0.
    always_comb begin
        if (prev_flit == '0) begin
            expect_flit = {1'b1, {(DATA_W-1){1'b0}}};
        end else if (&prev_flit || !prev_flit[DATA_W-1]) begin
            expect_flit = {1'b0, prev_flit[DATA_W-1:1]};
        end else begin
            expect_flit = {1'b1, prev_flit[DATA_W-1:1]};
        end
    end

    assign flit_err = primed && (flit_data != expect_flit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            primed <= 1'b0;
        end else if (flit_valid) begin
            primed <= 1'b1;
        end
    end
`else
    assign flit_err = 1'b0;
`endif

    // Next-state values for a packet that absorbs the current flit.
    logic [LEN_W-1:0] base_len, len_nxt, base_err, err_nxt;
    logic [CNT_W-1:0] base_acc, acc_nxt;
    logic [CNT_W:0]   acc_sum;
    logic             close_len, close_gap, commit;
    rec_t             commit_rec;

    always_comb begin
        base_len = (state == OPEN) ? len     : '0;
        base_acc = (state == OPEN) ? acc     : '0;
        base_err = (state == OPEN) ? seq_err : '0;

        len_nxt = base_len + LEN_W'(1);
        acc_sum = {1'b0, base_acc} + (CNT_W+1)'(toggle);
        acc_nxt = acc_sum[CNT_W] ? '1 : acc_sum[CNT_W-1:0];
        err_nxt = (flit_err && !(&base_err)) ? base_err + LEN_W'(1) : base_err;

        close_len = flit_valid && (len_nxt == LEN_W'(MAX_LEN));
        close_gap = (state == OPEN) && !flit_valid && (gap_cnt == GAP_W'(IDLE_GAP - 1));
        commit    = close_len || close_gap;

        if (close_len) begin
            commit_rec = '{len: len_nxt, toggles: acc_nxt, seq_err: err_nxt};
        end else begin
            commit_rec = '{len: len, toggles: acc, seq_err: seq_err};
        end
    end

    // A MAX_LEN close lands in IDLE, so a flit on the next cycle opens a packet with no gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            prev_flit <= '0;
            len       <= '0;
            acc       <= '0;
            seq_err   <= '0;
            gap_cnt   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            if (flit_valid) begin
                prev_flit <= flit_data;
            end
            if (commit) begin
                state   <= IDLE;
                len     <= '0;
                acc     <= '0;
                seq_err <= '0;
                gap_cnt <= '0;
            end else if (flit_valid) begin
                state   <= OPEN;
                len     <= len_nxt;
                acc     <= acc_nxt;
                seq_err <= err_nxt;
                gap_cnt <= '0;
            end else if (state == OPEN) begin
                gap_cnt <= gap_cnt + GAP_W'(1);
            end
        end
    end

    // Single-entry output register; a commit into a full, unaccepted register is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_valid <= 1'b0;
            rec        <= '0;
            drop_cnt   <= '0;
        end else if (commit && (!stat_valid || stat_ready)) begin
            stat_valid <= 1'b1;
            rec        <= commit_rec;
        end else if (commit) begin
            if (drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end else if (stat_valid && stat_ready) begin
            stat_valid <= 1'b0;
            rec        <= '0;
        end
    end

    assign stat_len     = rec.len;
    assign stat_toggles = rec.toggles;
    assign stat_seq_err = rec.seq_err;
    assign busy         = (state == OPEN);

endmodule
